countdown_arbiter: RTL and testbench

COUNTDOWN_ARBITER -- requirements
Module: countdown_arbiter

---
 rtl/countdown_arbiter.sv | 124 ++++++++++++
 tb/tb_countdown_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/countdown_arbiter.sv
// Round-robin arbiter that lends one shared down-counter to a requester at a time.
// Each grant loads the winner's start value, counts to zero, then pulses done for one cycle.
module countdown_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int W     = 4,
    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] load_val,
    input  logic               hold,
    output logic [N_REQ-1:0]   gnt,
    output logic [IDW-1:0]     gnt_id,
    output logic [W-1:0]       ctr,
    output logic               busy,
    output logic [N_REQ-1:0]   done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]     ctr_q, ctr_d;
    logic [N_REQ-1:0] done_q, done_d;

    logic [W-1:0]     load_arr [N_REQ];
    logic             found;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   cand;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign load_arr[i] = load_val[i*W +: W];
    end

    // Search starts just past the last grantee so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % N_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        ctr_d    = ctr_q;
        done_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d         = ST_COUNT;
                    gnt_d           = '0;
                    gnt_d[winner]   = 1'b1;
                    gnt_id_d        = winner;
                    ptr_d           = winner;
                    ctr_d           = load_arr[winner];
                end
            end
            ST_COUNT: begin
                // A grantee withdrawing its request abandons the count without a done pulse.
                if (!req[gnt_id_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    ctr_d   = '0;
                end else if (!hold) begin
                    if (ctr_q == '0) begin
                        state_d          = ST_DONE;
                        done_d[gnt_id_q] = 1'b1;
                    end else begin
                        ctr_d = ctr_q - W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= IDW'(N_REQ - 1);
            ctr_q    <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            ctr_q    <= ctr_d;
            done_q   <= done_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign ctr    = ctr_q;
    assign done   = done_q;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_countdown_arbiter.sv
// Directed bench for countdown_arbiter with hand-computed expectations.
module tb_countdown_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] load_val;
    logic        hold;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic [3:0]  ctr;
    logic        busy;
    logic [3:0]  done;

    int checks = 0;
    int errors = 0;

    countdown_arbiter #(.N_REQ(4), .W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .load_val (load_val),
        .hold     (hold),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .ctr      (ctr),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] gnt_e, input logic [3:0] done_e,
                             input logic [3:0] ctr_e, input logic busy_e);
        check({tag, ".gnt"},  32'(gnt),  32'(gnt_e));
        check({tag, ".done"}, 32'(done), 32'(done_e));
        check({tag, ".ctr"},  32'(ctr),  32'(ctr_e));
        check({tag, ".busy"}, 32'(busy), 32'(busy_e));
    endtask

    initial begin
        int order [5];
        logic [3:0] oh;
        order = '{0, 1, 2, 3, 0};

        rst = 1'b0; req = 4'b0000; load_val = 16'h0000; hold = 1'b0;
        #13;
        check_all("reset", 4'b0000, 4'b0000, 4'h0, 1'b0);
        check("reset.gnt_id", 32'(gnt_id), 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        tick();
        check_all("idle", 4'b0000, 4'b0000, 4'h0, 1'b0);

        // Round robin: all requesting, load 1 each
        req = 4'b1111; load_val = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            oh = 4'b0001 << order[i];
            tick();
            check_all("rr.grant", oh, 4'b0000, 4'h1, 1'b1);
            check("rr.gnt_id", 32'(gnt_id), 32'(order[i]));
            tick();
            check_all("rr.zero", oh, 4'b0000, 4'h0, 1'b1);
            tick();
            check_all("rr.done", oh, oh, 4'h0, 1'b1);
            if (i == 4) req = 4'b0000;
            tick();
            check_all("rr.idle", 4'b0000, 4'b0000, 4'h0, 1'b0);
        end

        // Basic: requester 0, load 3; req drops during DONE
        req = 4'b0001; load_val = 16'h0003;
        tick(); check_all("basic.c1", 4'b0001, 4'b0000, 4'h3, 1'b1);
        tick(); check_all("basic.c2", 4'b0001, 4'b0000, 4'h2, 1'b1);
        tick(); check_all("basic.c3", 4'b0001, 4'b0000, 4'h1, 1'b1);
        tick(); check_all("basic.c4", 4'b0001, 4'b0000, 4'h0, 1'b1);
        tick(); check_all("basic.c5", 4'b0001, 4'b0001, 4'h0, 1'b1);
        req = 4'b0000;
        tick(); check_all("basic.end", 4'b0000, 4'b0000, 4'h0, 1'b0);

        // Hold: requester 2, load 4, others and grantee load change mid-count
        req = 4'b0100; load_val = 16'h0400;
        tick(); check_all("hold.c1", 4'b0100, 4'b0000, 4'h4, 1'b1);
        check("hold.gnt_id", 32'(gnt_id), 32'd2);
        req = 4'b0101; load_val = 16'h0F0F;
        tick(); check_all("hold.c2", 4'b0100, 4'b0000, 4'h3, 1'b1);
        tick(); check_all("hold.c3", 4'b0100, 4'b0000, 4'h2, 1'b1);
        hold = 1'b1;
        tick(); check_all("hold.c4", 4'b0100, 4'b0000, 4'h2, 1'b1);
        tick(); check_all("hold.c5", 4'b0100, 4'b0000, 4'h2, 1'b1);
        tick(); check_all("hold.c6", 4'b0100, 4'b0000, 4'h2, 1'b1);
        hold = 1'b0;
        tick(); check_all("hold.c7", 4'b0100, 4'b0000, 4'h1, 1'b1);
        tick(); check_all("hold.c8", 4'b0100, 4'b0000, 4'h0, 1'b1);
        tick(); check_all("hold.c9", 4'b0100, 4'b0100, 4'h0, 1'b1);
        req = 4'b0000; hold = 1'b1;
        tick(); check_all("hold.end", 4'b0000, 4'b0000, 4'h0, 1'b0);
        hold = 1'b0;

        // Abort: requester 1, load 5, drop at ctr=3
        req = 4'b0010; load_val = 16'h0050;
        tick(); check_all("abort.c1", 4'b0010, 4'b0000, 4'h5, 1'b1);
        tick(); check_all("abort.c2", 4'b0010, 4'b0000, 4'h4, 1'b1);
        tick(); check_all("abort.c3", 4'b0010, 4'b0000, 4'h3, 1'b1);
        req = 4'b0000;
        tick(); check_all("abort.end", 4'b0000, 4'b0000, 4'h0, 1'b0);
        check("abort.gnt_id", 32'(gnt_id), 32'd1);
        tick(); check_all("abort.after", 4'b0000, 4'b0000, 4'h0, 1'b0);

        // Pointer kept at aborted index 1: requesters 0 and 2 -> 2 wins
        req = 4'b0101; load_val = 16'h0000;
        tick(); check_all("ptr.grant", 4'b0100, 4'b0000, 4'h0, 1'b1);
        req = 4'b0000;
        tick(); check_all("ptr.abort", 4'b0000, 4'b0000, 4'h0, 1'b0);

        // Zero load on requester 0
        req = 4'b0001; load_val = 16'h0000;
        tick(); check_all("zero.c1", 4'b0001, 4'b0000, 4'h0, 1'b1);
        tick(); check_all("zero.c2", 4'b0001, 4'b0001, 4'h0, 1'b1);
        req = 4'b0000;
        tick(); check_all("zero.end", 4'b0000, 4'b0000, 4'h0, 1'b0);

        // Reset mid-count at ctr=6, then regrant to requester 2
        req = 4'b0100; load_val = 16'h0900;
        tick(); check_all("rst.c1", 4'b0100, 4'b0000, 4'h9, 1'b1);
        tick(); tick(); tick();
        check_all("rst.c4", 4'b0100, 4'b0000, 4'h6, 1'b1);
        #2 rst = 1'b0;
        #1 check_all("rst.async", 4'b0000, 4'b0000, 4'h0, 1'b0);
        check("rst.gnt_id", 32'(gnt_id), 32'd0);
        tick(); check_all("rst.held", 4'b0000, 4'b0000, 4'h0, 1'b0);
        rst = 1'b1;
        tick(); check_all("rst.regrant", 4'b0100, 4'b0000, 4'h9, 1'b1);
        check("rst.regrant_id", 32'(gnt_id), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
